crypto_block_sequencer: RTL and testbench
=========================================

CRYPTO_BLOCK_SEQUENCER -- requirements
Module: crypto_block_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum WAIT cycles allowed for engine done (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports cfg_algo_sel, input, 1, per-packet algorithm select (0:AES, 1:SM4), and cfg_key, input, 128, per-packet key.
REQ-005 SHALL have ports s_valid (in, 1), s_ready (out, 1), s_data (in, 128) and s_last (in, 1), forming the input block stream.
REQ-006 SHALL have ports m_valid (out, 1), m_ready (in, 1), m_data (out, 128) and m_last (out, 1), forming the output block stream.
REQ-007 SHALL have engine-side ports eng_algo_sel (out, 1), eng_start (out, 1), eng_key (out, 128), eng_din (out, 128), eng_done (in, 1), eng_busy (in, 1) and eng_dout (in, 128).
REQ-008 SHALL have status ports blk_cnt (out, 16), the count of delivered blocks; timeout_err (out, 1), the sticky error flag; clr_err (in, 1), which clears the error; and seq_busy (out, 1), high when state is not IDLE.

Function
REQ-009 SHALL implement a registered FSM with states IDLE, ISSUE, WAIT, OUT and ERR.
REQ-010 In IDLE, s_ready SHALL be 1; in all other states it SHALL be 0.
REQ-011 On an IDLE handshake (s_valid && s_ready), the block SHALL latch s_data into eng_din, latch s_last into last_q, and move to ISSUE.
REQ-012 If pkt_open==0 at that handshake, the block SHALL also latch cfg_algo_sel and cfg_key into eng_algo_sel and eng_key, then set pkt_open=1.
REQ-013 While pkt_open==1, changes on cfg_* SHALL be ignored; eng_algo_sel and eng_key SHALL stay stable for the whole packet.
REQ-014 In ISSUE with eng_busy==0, eng_start SHALL be asserted for exactly one cycle, the timer SHALL be cleared, and the state SHALL move to WAIT.
REQ-015 In ISSUE with eng_busy==1, eng_start SHALL stay 0 and the state SHALL remain ISSUE.
REQ-016 eng_start SHALL be 0 in every state other than ISSUE.
REQ-017 In WAIT, when eng_done==1, eng_dout SHALL be captured into m_data, last_q SHALL be copied to m_last, and the state SHALL move to OUT.
REQ-018 In WAIT without eng_done, the timer SHALL increment.
REQ-019 If the timer reaches TIMEOUT_CYCLES-1 without done, timeout_err SHALL be set to 1 and the state SHALL move to ERR.
REQ-020 If eng_done and the timeout condition occur in the same cycle, done SHALL win: the state goes to OUT and no error is raised.
REQ-021 eng_done SHALL be ignored outside WAIT.
REQ-022 In OUT, m_valid SHALL be 1, and m_data and m_last SHALL be held stable until m_ready==1.
REQ-023 On the OUT handshake, blk_cnt SHALL increment (modulo 2^16, so 16'hFFFF wraps to 0), pkt_open SHALL clear if m_last==1, and the state SHALL return to IDLE in the next cycle.
REQ-024 m_valid SHALL be 0 in every state other than OUT.
REQ-025 In ERR, s_ready and m_valid SHALL both be 0.
REQ-026 In ERR, clr_err==1 SHALL clear timeout_err and pkt_open and move the state to IDLE; clr_err SHALL have no effect in any other state.
REQ-027 Latency: with the input handshake in cycle T, eng_start SHALL be high in T+1 (engine idle); with eng_done in cycle D, m_valid SHALL be high from D+1.
REQ-028 Only one block SHALL be in flight at a time; there SHALL be no input buffering beyond the single holding register.

Reset
REQ-029 While rst_n==0, the state SHALL be IDLE and m_valid, m_last, m_data, eng_start, eng_din, eng_key, eng_algo_sel, blk_cnt, timeout_err, seq_busy, pkt_open and the timer SHALL all be 0.
REQ-030 After reset release, s_ready SHALL be 1.
REQ-031 Assertion of rst_n mid-operation, in any state, SHALL abandon the in-flight block with no output handshake.

Verification
REQ-032 Single AES block: cfg_algo_sel=0, s_data=128'h0011..ff, s_last=1, engine model done 10 cycles after start -> exactly one eng_start pulse; m_data equals eng_dout; m_last=1; blk_cnt=1.
REQ-033 Packet key/algo lock: 3-block packet with SM4 and key K1, cfg switched to AES/K2 after block 1 -> eng_algo_sel=1 and eng_key=K1 for all 3 blocks; the next packet uses AES/K2.
REQ-034 Backpressure: m_ready held 0 for 20 cycles in OUT -> m_valid stays 1, m_data unchanged, s_ready=0, blk_cnt unchanged until the handshake.
REQ-035 Timeout: engine never asserts done, TIMEOUT_CYCLES=8 -> timeout_err=1 after 8 WAIT cycles, ERR entered, s_ready=0; clr_err pulse -> IDLE, timeout_err=0.
REQ-036 Busy hold-off and boundary: eng_busy=1 for 5 cycles at ISSUE -> eng_start delayed until busy is 0; done coincident with the timeout cycle -> OUT, no error; blk_cnt preset path 16'hFFFF plus one block -> 0.
REQ-037 Reset mid-WAIT: rst_n pulsed low -> all outputs 0, no m_valid, s_ready=1 after release.

Source files
------------

// File: rtl/crypto_block_sequencer.sv
// One-block-in-flight sequencer between a 128-bit block stream and an AES/SM4 engine.
// Each packet's algorithm and key are locked by its first block and held until the last block is delivered.
module crypto_block_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [15:0] BLK_CNT_INIT   = 16'h0000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_algo_sel,
   input  logic [127:0] cfg_key,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [127:0] s_data,
   input  logic         s_last,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic         m_last,
   output logic         eng_algo_sel,
   output logic         eng_start,
   output logic [127:0] eng_key,
   output logic [127:0] eng_din,
   input  logic         eng_done,
   input  logic         eng_busy,
   input  logic [127:0] eng_dout,
   output logic [15:0]  blk_cnt,
   output logic         timeout_err,
   input  logic         clr_err,
   output logic         seq_busy
);
   localparam int unsigned DW = 128;
   localparam int unsigned CW = 16;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_ERR} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] timer;
   logic          last_q;
   logic          pkt_open;
   logic          tmo_c;

   assign tmo_c = (timer == CW'(TIMEOUT_CYCLES - 1));

   // Next-state decode; done takes priority over the timeout in WAIT
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (s_valid)   state_nxt = S_ISSUE;
         S_ISSUE: if (eng_start) state_nxt = S_WAIT;
         S_WAIT: begin
            if (eng_done)   state_nxt = S_OUT;
            else if (tmo_c) state_nxt = S_ERR;
         end
         S_OUT:   if (m_ready)   state_nxt = S_IDLE;
         S_ERR:   if (clr_err)   state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // State, datapath and registered status; outputs are decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         s_ready      <= 1'b1;
         seq_busy     <= 1'b0;
         m_valid      <= 1'b0;
         m_data       <= '0;
         m_last       <= 1'b0;
         eng_start    <= 1'b0;
         eng_din      <= '0;
         eng_key      <= '0;
         eng_algo_sel <= 1'b0;
         blk_cnt      <= BLK_CNT_INIT;
         timeout_err  <= 1'b0;
         pkt_open     <= 1'b0;
         last_q       <= 1'b0;
         timer        <= '0;
      end else begin
         state     <= state_nxt;
         s_ready   <= (state_nxt == S_IDLE);
         seq_busy  <= (state_nxt != S_IDLE);
         m_valid   <= (state_nxt == S_OUT);
         // single start pulse on the first ISSUE cycle that follows an idle engine
         eng_start <= (state_nxt == S_ISSUE) && !eng_busy;

         if (state == S_IDLE && s_valid) begin
            eng_din <= s_data;
            last_q  <= s_last;
            if (!pkt_open) begin
               eng_algo_sel <= cfg_algo_sel;
               eng_key      <= cfg_key;
               pkt_open     <= 1'b1;
            end
         end

         if (state == S_ISSUE) timer <= '0;

         if (state == S_WAIT) begin
            if (eng_done) begin
               m_data <= DW'(eng_dout);
               m_last <= last_q;
            end else if (tmo_c) begin
               timeout_err <= 1'b1;
            end else begin
               timer <= timer + CW'(1);
            end
         end

         if (state == S_OUT && m_ready) begin
            blk_cnt <= blk_cnt + CW'(1);
            if (m_last) pkt_open <= 1'b0;
         end

         if (state == S_ERR && clr_err) begin
            timeout_err <= 1'b0;
            pkt_open    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crypto_block_sequencer.sv
// Bench for crypto_block_sequencer: random block traffic scored against a packet/key-lock reference model.
// Instance a uses default timing; instance b has a short timeout and a preset block counter for the wrap case.
module tb_crypto_block_sequencer;
   localparam int unsigned DW    = 128;
   localparam int          TMO_A = 64;
   localparam int          TMO_B = 8;
   localparam logic [15:0] INIT_B = 16'hFFFF;

   logic          clk = 1'b0;
   logic          rst_n, cfg_algo_sel, s_valid, s_last, m_ready, eng_done, eng_busy, clr_err;
   logic [DW-1:0] cfg_key, s_data, eng_dout;

   logic          s_ready_a, m_valid_a, m_last_a, eng_algo_sel_a, eng_start_a, timeout_err_a, seq_busy_a;
   logic [DW-1:0] m_data_a, eng_key_a, eng_din_a;
   logic [15:0]   blk_cnt_a;
   logic          s_ready_b, m_valid_b, m_last_b, eng_algo_sel_b, eng_start_b, timeout_err_b, seq_busy_b;
   logic [DW-1:0] m_data_b, eng_key_b, eng_din_b;
   logic [15:0]   blk_cnt_b;

   logic          sel_b;
   logic          o_s_ready, o_m_valid, o_m_last, o_eng_algo_sel, o_eng_start, o_timeout_err, o_seq_busy;
   logic [DW-1:0] o_m_data, o_eng_key, o_eng_din;
   logic [15:0]   o_blk_cnt;

   int            n_chk = 0;
   int            n_err = 0;
   int            n_start = 0;

   // reference model: packet lock and delivered-block count
   logic          exp_open;
   logic          exp_algo;
   logic [DW-1:0] exp_key;
   logic [15:0]   exp_cnt;

   always #5 clk = ~clk;

   crypto_block_sequencer dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_algo_sel(cfg_algo_sel), .cfg_key(cfg_key),
      .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a),
      .eng_algo_sel(eng_algo_sel_a), .eng_start(eng_start_a), .eng_key(eng_key_a), .eng_din(eng_din_a),
      .eng_done(eng_done), .eng_busy(eng_busy), .eng_dout(eng_dout),
      .blk_cnt(blk_cnt_a), .timeout_err(timeout_err_a), .clr_err(clr_err), .seq_busy(seq_busy_a)
   );

   crypto_block_sequencer #(.TIMEOUT_CYCLES(TMO_B), .BLK_CNT_INIT(INIT_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_algo_sel(cfg_algo_sel), .cfg_key(cfg_key),
      .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b),
      .eng_algo_sel(eng_algo_sel_b), .eng_start(eng_start_b), .eng_key(eng_key_b), .eng_din(eng_din_b),
      .eng_done(eng_done), .eng_busy(eng_busy), .eng_dout(eng_dout),
      .blk_cnt(blk_cnt_b), .timeout_err(timeout_err_b), .clr_err(clr_err), .seq_busy(seq_busy_b)
   );

   assign o_s_ready      = sel_b ? s_ready_b      : s_ready_a;
   assign o_m_valid      = sel_b ? m_valid_b      : m_valid_a;
   assign o_m_last       = sel_b ? m_last_b       : m_last_a;
   assign o_eng_algo_sel = sel_b ? eng_algo_sel_b : eng_algo_sel_a;
   assign o_eng_start    = sel_b ? eng_start_b    : eng_start_a;
   assign o_timeout_err  = sel_b ? timeout_err_b  : timeout_err_a;
   assign o_seq_busy     = sel_b ? seq_busy_b     : seq_busy_a;
   assign o_m_data       = sel_b ? m_data_b       : m_data_a;
   assign o_eng_key      = sel_b ? eng_key_b      : eng_key_a;
   assign o_eng_din      = sel_b ? eng_din_b      : eng_din_a;
   assign o_blk_cnt      = sel_b ? blk_cnt_b      : blk_cnt_a;

   always @(negedge clk) if (rst_n && o_eng_start) n_start++;

   task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // stand-in engine transform so each result depends on data, key and algorithm
   function automatic logic [DW-1:0] eng_fn(input logic [DW-1:0] d, input logic [DW-1:0] k, input logic a);
      return d ^ {k[63:0], k[127:64]} ^ {DW{a}};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; eng_done = 1'b0; eng_busy = 1'b0; clr_err = 1'b0;
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      exp_open = 1'b0;
      exp_cnt  = sel_b ? INIT_B : 16'h0000;
      @(negedge clk);
   endtask

   // One block end to end; dly<0 means the engine never answers (timeout path)
   task automatic run_block(input logic [DW-1:0] data, input logic last, input logic algo,
                            input logic [DW-1:0] key, input int busy, input int dly, input int stall);
      int            k;
      int            starts0;
      logic [DW-1:0] dout;
      if (!exp_open) begin
         exp_algo = algo; exp_key = key; exp_open = 1'b1;
      end
      starts0 = n_start;
      @(negedge clk);
      chk("s_ready_idle", o_s_ready, 1);
      cfg_algo_sel = algo; cfg_key = key; s_data = data; s_last = last; s_valid = 1'b1;
      eng_busy = (busy > 0);
      @(negedge clk);
      s_valid = 1'b0; s_data = rnd128(); cfg_algo_sel = ~algo; cfg_key = ~key;
      chk("s_ready_held", o_s_ready, 0);
      chk("seq_busy", o_seq_busy, 1);
      chk("eng_din", o_eng_din, data);
      chk("eng_key", o_eng_key, exp_key);
      chk("eng_algo", o_eng_algo_sel, exp_algo);
      k = 1;
      while (!o_eng_start && k < 40) begin
         eng_busy = (k < busy);
         @(negedge clk);
         k++;
      end
      eng_busy = 1'b0;
      chk("start_latency", k, busy + 1);
      @(negedge clk);
      chk("start_pulse", o_eng_start, 0);
      if (dly < 0) begin
         repeat ((sel_b ? TMO_B : TMO_A) - 1) @(negedge clk);
         chk("tmo_early", o_timeout_err, 0);
         chk("tmo_no_valid", o_m_valid, 0);
         @(negedge clk);
         chk("tmo_err", o_timeout_err, 1);
         chk("err_s_ready", o_s_ready, 0);
         chk("err_m_valid", o_m_valid, 0);
         chk("err_busy", o_seq_busy, 1);
         return;
      end
      repeat (dly - 1) @(negedge clk);
      chk("wait_no_valid", o_m_valid, 0);
      dout = eng_fn(data, exp_key, exp_algo);
      eng_done = 1'b1; eng_dout = dout;
      @(negedge clk);
      eng_done = 1'b0; eng_dout = rnd128();
      chk("m_valid", o_m_valid, 1);
      chk("m_data", o_m_data, dout);
      chk("m_last", o_m_last, last);
      chk("no_err", o_timeout_err, 0);
      for (int i = 0; i < stall; i++) begin
         eng_done = 1'($urandom); eng_dout = rnd128(); clr_err = 1'($urandom);
         @(negedge clk);
         chk("bp_valid", o_m_valid, 1);
         chk("bp_data", o_m_data, dout);
         chk("bp_s_ready", o_s_ready, 0);
         chk("bp_cnt", o_blk_cnt, exp_cnt);
      end
      eng_done = 1'b0; clr_err = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      if (last) exp_open = 1'b0;
      chk("post_valid", o_m_valid, 0);
      chk("post_s_ready", o_s_ready, 1);
      chk("blk_cnt", o_blk_cnt, exp_cnt);
      chk("start_count", n_start - starts0, 1);
   endtask

   initial begin
      logic [DW-1:0] k1, k2;
      cfg_algo_sel = 1'b0; cfg_key = '0; s_data = '0; s_last = 1'b0; eng_dout = '0;
      s_valid = 1'b0; m_ready = 1'b0; eng_done = 1'b0; eng_busy = 1'b0; clr_err = 1'b0;
      sel_b = 1'b0; rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_m_valid", o_m_valid, 0);
      chk("rst_eng_start", o_eng_start, 0);
      chk("rst_eng_din", o_eng_din, 0);
      chk("rst_eng_key", o_eng_key, 0);
      chk("rst_blk_cnt", o_blk_cnt, 0);
      chk("rst_seq_busy", o_seq_busy, 0);
      chk("rst_blk_cnt_b", blk_cnt_b, INIT_B);

      // short-timeout instance: coincident done, counter wrap, timeout and clear
      sel_b = 1'b1;
      do_reset();
      run_block(rnd128(), 1'b1, 1'b0, rnd128(), 0, TMO_B, 2);
      chk("cnt_wrap", o_blk_cnt, 0);
      k1 = rnd128(); k2 = rnd128();
      run_block(rnd128(), 1'b0, 1'b1, k1, 0, -1, 0);
      repeat (3) begin
         eng_done = 1'b1;
         @(negedge clk);
         chk("err_hold_ready", o_s_ready, 0);
         chk("err_hold_flag", o_timeout_err, 1);
      end
      eng_done = 1'b0; clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0; exp_open = 1'b0;
      chk("clr_s_ready", o_s_ready, 1);
      chk("clr_flag", o_timeout_err, 0);
      chk("clr_busy", o_seq_busy, 0);
      run_block(rnd128(), 1'b1, 1'b0, k2, 0, 3, 0);

      // default instance
      sel_b = 1'b0;
      do_reset();
      run_block(128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0, rnd128(), 0, 10, 0);
      k1 = rnd128(); k2 = rnd128();
      run_block(rnd128(), 1'b0, 1'b1, k1, 0, 4, 0);
      run_block(rnd128(), 1'b0, 1'b0, k2, 1, 6, 1);
      run_block(rnd128(), 1'b1, 1'b0, k2, 0, 2, 0);
      run_block(rnd128(), 1'b1, 1'b0, k2, 0, 2, 0);
      chk("next_pkt_key", o_eng_key, k2);
      run_block(rnd128(), 1'b1, 1'($urandom), rnd128(), 0, 5, 20);
      run_block(rnd128(), 1'b1, 1'($urandom), rnd128(), 5, 4, 0);
      run_block(rnd128(), 1'b1, 1'b1, rnd128(), 0, 1, 0);
      for (int n = 0; n < 25; n++)
         run_block(rnd128(), ($urandom_range(0, 2) == 0), 1'($urandom), rnd128(),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 20)), int'($urandom_range(0, 4)));

      // reset while waiting for the engine
      @(negedge clk);
      cfg_algo_sel = 1'b1; cfg_key = rnd128(); s_data = rnd128(); s_last = 1'b1; s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0; eng_done = 1'b1; eng_dout = rnd128();
      #1;
      chk("mid_m_valid", o_m_valid, 0);
      chk("mid_eng_start", o_eng_start, 0);
      chk("mid_eng_din", o_eng_din, 0);
      chk("mid_eng_key", o_eng_key, 0);
      chk("mid_algo", o_eng_algo_sel, 0);
      chk("mid_m_data", o_m_data, 0);
      chk("mid_m_last", o_m_last, 0);
      chk("mid_blk_cnt", o_blk_cnt, 0);
      chk("mid_err", o_timeout_err, 0);
      chk("mid_busy", o_seq_busy, 0);
      @(negedge clk);
      rst_n = 1'b1; exp_cnt = 16'h0000; exp_open = 1'b0;
      repeat (2) @(negedge clk);
      eng_done = 1'b0;
      chk("mid_rel_ready", o_s_ready, 1);
      chk("mid_rel_valid", o_m_valid, 0);
      run_block(rnd128(), 1'b1, 1'b0, rnd128(), 0, 7, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
